// File: rtl/baud_tick_gen.sv
// Fractional clock-enable generator for UART timing: oversample tick, baud tick
// and baud-rate square wave, with a run-time loadable divisor and phase restart.
module baud_tick_gen #(
    parameter int CNT_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = 54,
    parameter int DEFAULT_FRAC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic             sync_clr,
    output logic             os_tick,
    output logic             baud_tick,
    output logic             baud_clk,
    output logic [CNT_W-1:0] act_int
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0]  DEF_INT  = CNT_W'(DEFAULT_INT);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_FRAC);
    localparam logic [CNT_W-1:0]  MIN_INT  = CNT_W'(2);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [CNT_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_frac_acc;
    logic              r_carry_q;
    logic [OS_W-1:0]   r_os_cnt;
    logic              r_os_tick;
    logic              r_baud_tick;
    logic              r_baud_clk;

    logic [CNT_W:0]    w_period_m1;
    logic              w_period_end;
    logic [FRAC_W:0]   w_frac_sum;
    logic [CNT_W-1:0]  w_load_int;
    logic              w_os_wrap;

    // ">=" rather than "==" so a load that shrinks the divisor below the
    // running count terminates the current period on the next enabled cycle.
    assign w_period_m1  = {1'b0, r_act_int} + {{CNT_W{1'b0}}, r_carry_q} - {{CNT_W{1'b0}}, 1'b1};
    assign w_period_end = ({1'b0, r_cnt} >= w_period_m1);
    assign w_frac_sum   = {1'b0, r_frac_acc} + {1'b0, r_act_frac};
    assign w_load_int   = (div_int < MIN_INT) ? MIN_INT : div_int;
    assign w_os_wrap    = (r_os_cnt == OS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_int   <= DEF_INT;
            r_act_frac  <= DEF_FRAC;
            r_cnt       <= '0;
            r_frac_acc  <= '0;
            r_carry_q   <= 1'b0;
            r_os_cnt    <= '0;
            r_os_tick   <= 1'b0;
            r_baud_tick <= 1'b0;
            r_baud_clk  <= 1'b0;
        end else begin
            if (load) begin
                r_act_int  <= w_load_int;
                r_act_frac <= div_frac;
            end
            if (sync_clr) begin
                r_cnt       <= '0;
                r_frac_acc  <= '0;
                r_carry_q   <= 1'b0;
                r_os_cnt    <= '0;
                r_os_tick   <= 1'b0;
                r_baud_tick <= 1'b0;
                r_baud_clk  <= 1'b0;
            end else if (en) begin
                if (w_period_end) begin
                    r_cnt                   <= '0;
                    {r_carry_q, r_frac_acc} <= w_frac_sum;
                    r_os_tick               <= 1'b1;
                    r_baud_tick             <= w_os_wrap;
                    r_os_cnt                <= w_os_wrap ? '0 : r_os_cnt + OS_W'(1);
                    if (w_os_wrap) begin
                        r_baud_clk <= 1'b0;
                    end else if (r_os_cnt == OS_HALF) begin
                        r_baud_clk <= 1'b1;
                    end
                end else begin
                    r_cnt       <= r_cnt + CNT_W'(1);
                    r_os_tick   <= 1'b0;
                    r_baud_tick <= 1'b0;
                end
            end else begin
                r_os_tick   <= 1'b0;
                r_baud_tick <= 1'b0;
            end
        end
    end

    assign os_tick   = r_os_tick;
    assign baud_tick = r_baud_tick;
    assign baud_clk  = r_baud_clk;
    assign act_int   = r_act_int;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: tick spacing, fractional pattern, clamp,
// gating, phase restart and reset, checked with immediate assertions.
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        sync_clr;
    logic        os_tick;
    logic        baud_tick;
    logic        baud_clk;
    logic [15:0] act_int;

    int checks = 0;
    int errors = 0;

    baud_tick_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .sync_clr  (sync_clr),
        .os_tick   (os_tick),
        .baud_tick (baud_tick),
        .baud_clk  (baud_clk),
        .act_int   (act_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("check %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Counts negedges until os_tick is seen (bounded by budget).
    task automatic wait_os(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (os_tick !== 1'b1 && n < budget);
    endtask

    // Counts negedges until baud_tick, plus how many of them saw baud_clk high.
    task automatic wait_baud(input int budget, output int n, output int hi);
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (baud_clk === 1'b1) hi++;
        end while (baud_tick !== 1'b1 && n < budget);
    endtask

    initial begin
        int n;
        int hi;
        int p0;
        int p1;
        int tick_seen;

        rst = 1'b1; en = 1'b0; load = 1'b0; sync_clr = 1'b0;
        div_int = '0; div_frac = '0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_os_tick", os_tick, 0);
        check("rst_baud_tick", baud_tick, 0);
        check("rst_baud_clk", baud_clk, 0);
        check("rst_act_int", act_int, 54);

        // Defaults: 54.25 cycle oversample period
        rst = 1'b0; en = 1'b1;
        wait_os(2000, n); check("def_first_os", n, 54);
        wait_os(2000, n); check("def_p2", n, 54);
        wait_os(2000, n); check("def_p3", n, 54);
        wait_os(2000, n); check("def_p4", n, 54);
        wait_os(2000, n); check("def_p5_long", n, 55);
        wait_baud(2000, n, hi);
        check("def_baud_seen", baud_tick, 1);
        check("def_baud_clk_low_at_tick", baud_clk, 0);
        check("def_os_with_baud", os_tick, 1);
        wait_baud(2000, n, hi);
        check("def_baud_period", n, 868);
        check("def_baud_high", hi, 434);

        // Integer divisor 4, then phase restart
        load = 1'b1; div_int = 16'd4; div_frac = 4'd0;
        @(negedge clk);
        load = 1'b0;
        check("int_act_int", act_int, 4);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        check("int_sync_no_tick", os_tick, 0);
        check("int_sync_baud_clk", baud_clk, 0);
        wait_os(200, n); check("int_first_os", n, 4);
        wait_os(200, n); check("int_os_period", n, 4);
        wait_baud(200, n, hi);
        wait_baud(200, n, hi);
        check("int_baud_period", n, 64);
        check("int_baud_high", hi, 32);

        // Clamp to 2 with half-cycle fraction, loaded together with sync_clr
        load = 1'b1; sync_clr = 1'b1; div_int = 16'd0; div_frac = 4'd8;
        @(negedge clk);
        load = 1'b0; sync_clr = 1'b0;
        check("clamp_act_int", act_int, 2);
        wait_os(50, n); check("clamp_p1", n, 2);
        wait_os(50, n); check("clamp_p2", n, 2);
        wait_os(50, n); check("clamp_p3_long", n, 3);
        wait_os(50, p0);
        wait_os(50, p1);
        check("clamp_pair_sum", p0 + p1, 5);
        wait_baud(200, n, hi);
        wait_baud(200, n, hi);
        check("clamp_baud_period", n, 40);
        check("clamp_baud_high", hi, 20);

        // Back to defaults, then gate en for 37 cycles mid-period
        load = 1'b1; sync_clr = 1'b1; div_int = 16'd54; div_frac = 4'd4;
        @(negedge clk);
        load = 1'b0; sync_clr = 1'b0;
        wait_os(200, n); check("gate_first_os", n, 54);
        tick_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (os_tick === 1'b1) tick_seen++;
        end
        en = 1'b0;
        repeat (37) begin
            @(negedge clk);
            if (os_tick === 1'b1 || baud_tick === 1'b1) tick_seen++;
        end
        en = 1'b1;
        check("gate_no_ticks", tick_seen, 0);
        wait_os(200, n); check("gate_late_period", 20 + 37 + n, 91);

        // Advance to os_cnt == 9 (two events since the last restart)
        repeat (7) wait_os(200, n);
        check("sync9_baud_clk_high", baud_clk, 1);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        check("sync9_baud_clk_cleared", baud_clk, 0);
        check("sync9_no_tick", os_tick, 0);
        wait_baud(2000, n, hi);
        check("sync9_baud_delay", n + 1, 868);

        // Shrinking load below the running count ends the period next cycle
        repeat (30) @(negedge clk);
        load = 1'b1; div_int = 16'd10; div_frac = 4'd0;
        wait_os(200, n);
        load = 1'b0;
        check("shrink_end", n, 2);
        check("shrink_act_int", act_int, 10);

        // Reset mid-operation
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_act_int", act_int, 54);
        check("mid_rst_os_tick", os_tick, 0);
        check("mid_rst_baud_tick", baud_tick, 0);
        check("mid_rst_baud_clk", baud_clk, 0);
        rst = 1'b0;
        wait_os(200, n); check("mid_rst_first_os", n, 54);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
